vmx_result_collector: RTL and testbench
=======================================

Name: vmx_result_collector

Overview:
- Downstream stage of the vector-matrix PE chain: consumes the 32-bit partial sum leaving the last PE of a column.
- Requantizes each result to 16 bits, or to two 8-bit halves in SIMD mode, using a rounding arithmetic right shift with saturation.
- Buffers results in a small FIFO and presents them on a valid/ready stream toward the DMA/AXI write path.
- The PE array cannot stall, so input has no backpressure; words arriving when the buffer cannot accept them are dropped and flagged.

Parameters:
- PRODUCT_BITLEN, 32, width of incoming sum; fixed at 32 for this revision.
- FIFO_DEPTH, 8, result buffer entries; power of 2, at least 2.
- FRAME_LEN, 16, number of output transfers per frame; out_last marks the final one.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- clear  in  1  synchronous flush: pipeline, FIFO, frame counter and flags.
- simd_mode  in  1  1 = two 16-bit lane sums (8-bit mode), 0 = one 32-bit sum.
- in_valid  in  1  sum_in is a valid result this cycle.
- sum_in  in  32  signed sum from the last PE (sum_out of that PE).
- shift  in  5  right-shift amount; sampled together with sum_in.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  16  quantized result; in SIMD mode {upper_i8, lower_i8}.
- out_last  out  1  head is the FRAME_LEN-th transfer of the frame.
- fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a word was dropped.
- saturated  out  1  sticky: some result clipped.

Behaviour:
- Reset (rst_n=0 at posedge) and clear=1 have identical effect:
  - FIFO emptied, stage register invalid, frame counter 0.
  - out_valid=0, out_data=0, out_last=0, fifo_count=0, overflow=0, saturated=0.
  - rst_n has priority over every other input.
- Stage 1 (quantize register), on the posedge where in_valid=1:
  - 16-bit mode:
    - v = sum_in sign-extended to 33 bits.
    - If shift>0, add 1<<(shift-1) (round half up), then arithmetic shift right by shift.
    - Saturate to [-32768, 32767].
  - SIMD mode:
    - Each of sum_in[31:16] and sum_in[15:0] is a signed 16-bit lane, extended to 17 bits.
    - Shift amount s = min(shift, 15); apply the same rounding and arithmetic shift.
    - Saturate each lane to [-128, 127]; out word = {upper[7:0], lower[7:0]}.
  - Any clip sets saturated, which holds until rst_n or clear.
  - stage_valid <= in_valid each cycle.
- Stage 2 (FIFO write) when stage_valid=1:
  - Accepted if the FIFO is not full, or if it is full and a pop happens the same cycle (simultaneous push and pop on full is legal).
  - Otherwise the word is discarded, overflow is set (sticky), and FIFO contents are unchanged.
  - Each FIFO entry also stores a last bit, computed at write time from a write-side frame counter.
- Latency: in_valid at edge N, FIFO written at edge N+1, out_valid=1 after edge N+1. The head is show-ahead, driven from FIFO storage.
- Pop occurs when out_valid & out_ready.
  - out_data and out_last are stable while out_valid=1 and out_ready=0.
- Frame counter:
  - Counts accepted writes 0..FRAME_LEN-1; the entry written at count FRAME_LEN-1 has last=1.
  - Wraps to 0 after that entry.
  - Dropped words do not advance it.
- fifo_count: +1 on push only, -1 on pop only, unchanged on both or neither; range 0..FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH; full = (count==FIFO_DEPTH), empty = (count==0).
- A mode change (simd_mode) mid-stream affects only words sampled after the change; there is no flush.
- Reset or clear mid-stream discards all buffered and in-flight words. in_valid coincident with clear is dropped without setting overflow.

Test Plan:
- 16-bit rounding: simd_mode=0, shift=4, sum_in=0x00000128 -> out_data=0x0013 two edges later, saturated=0.
- Negative value and saturation:
  - sum_in=0xFFFFFFD8, shift=3 -> 0xFFFB.
  - Then sum_in=0x00100000, shift=0 -> 0x7FFF, saturated=1 and stays 1.
- SIMD: simd_mode=1, shift=2, sum_in=0x0190FF00 -> out_data=0x64C0.
  - Then sum_in=0x7FFF8000, shift=0 -> 0x7F80, saturated=1.
- Backpressure/overflow: FIFO_DEPTH=8, out_ready=0, 10 consecutive in_valid words 1..10 (shift=0) -> fifo_count=8, overflow=1.
  - Then raise out_ready -> outputs 1..8 in order, then out_valid=0.
- Full + simultaneous pop: FIFO full, out_ready=1 and stage_valid=1 in the same cycle -> no drop, fifo_count stays 8, overflow stays 0.
- Frames and clear: FRAME_LEN=4, stream 8 words with out_ready=1 -> out_last=1 only on transfers 4 and 8.
  - Then clear with 3 words buffered -> next edge fifo_count=0, out_valid=0, flags 0, frame restarts at 1.

Source files
------------

// File: rtl/vmx_result_collector.sv
// Requantizes 32-bit column sums to 16 bits (or two 8-bit SIMD lanes), buffers them and streams them out.
// Latency: sum sampled at edge N is written to the FIFO at edge N+1 and visible on out_* after that edge.
// Backpressure: none toward the PE array; out_ready stalls the head, and a word that finds the FIFO full is dropped (overflow).
// Ports: clk/rst_n/clear control; simd_mode, in_valid, sum_in, shift on the input side;
//        out_valid/out_ready/out_data/out_last stream; fifo_count occupancy; overflow/saturated sticky flags.
module vmx_result_collector #(
  parameter int PRODUCT_BITLEN = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int FRAME_LEN      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        simd_mode,
  input  logic                        in_valid,
  input  logic [PRODUCT_BITLEN-1:0]   sum_in,
  input  logic [4:0]                  shift,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0]                 out_data,
  output logic                        out_last,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        saturated
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [FW-1:0] FRAME_END = FW'(FRAME_LEN - 1);

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } entry_t;

  // One SIMD lane: 16-bit signed value, round-half-up shift, clip to int8.
  // Returns {clip, q[7:0]}. 17 bits hold 32767 + 2^14 without wrapping.
  function automatic logic [8:0] quant_lane(input logic [15:0] x, input logic [3:0] s);
    logic signed [16:0] v;
    logic signed [16:0] rnd;
    logic [8:0]         res;
    v   = {x[15], x};
    rnd = (s == 4'd0) ? 17'sd0 : (17'sd1 <<< (s - 4'd1));
    v   = (v + rnd) >>> s;
    if (v > 17'sd127)       res = {1'b1, 8'h7F};
    else if (v < -17'sd128) res = {1'b1, 8'h80};
    else                    res = {1'b0, v[7:0]};
    return res;
  endfunction

  // ---------------- quantizer (combinational, registered in stage 1) ----------------
  logic signed [32:0] w_rnd;
  logic signed [32:0] w_v;
  logic [3:0]         lane_shift;
  logic [8:0]         lane_hi;
  logic [8:0]         lane_lo;
  logic [15:0]        q_data;
  logic               q_clip;

  always_comb begin
    // 33 bits so that 0x7FFFFFFF plus the rounding term cannot wrap.
    w_rnd      = (shift == 5'd0) ? 33'sd0 : (33'sd1 <<< (shift - 5'd1));
    w_v        = ($signed({sum_in[31], sum_in}) + w_rnd) >>> shift;
    lane_shift = (shift > 5'd15) ? 4'd15 : shift[3:0];
    lane_hi    = quant_lane(sum_in[31:16], lane_shift);
    lane_lo    = quant_lane(sum_in[15:0], lane_shift);
    q_data     = w_v[15:0];
    q_clip     = 1'b0;
    if (simd_mode) begin
      q_data = {lane_hi[7:0], lane_lo[7:0]};
      q_clip = lane_hi[8] | lane_lo[8];
    end else if (w_v > 33'sd32767) begin
      q_data = 16'h7FFF;
      q_clip = 1'b1;
    end else if (w_v < -33'sd32768) begin
      q_data = 16'h8000;
      q_clip = 1'b1;
    end
  end

  logic        stage_valid;
  logic [15:0] stage_data;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
      saturated   <= 1'b0;
    end else begin
      stage_valid <= in_valid;
      if (in_valid) begin
        stage_data <= q_data;
        if (q_clip) saturated <= 1'b1;
      end
    end
  end

  // ---------------- result FIFO ----------------
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [FW-1:0] frame_cnt;
  logic          full;
  logic          pop;
  logic          push;
  logic          frame_end;

  assign full      = (count == FULL_CNT);
  assign pop       = out_valid && out_ready;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push      = stage_valid && (!full || pop);
  assign frame_end = (frame_cnt == FRAME_END);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{last: frame_end, data: stage_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (stage_valid && !push) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Head is read straight from storage; gated to zero while empty so the
  // stale contents never leak onto out_data.
  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr].data : 16'h0000;
  assign out_last   = out_valid ? mem[rd_ptr].last : 1'b0;
  assign fifo_count = count;

endmodule

// File: tb/tb_vmx_result_collector.sv
module tb_vmx_result_collector;

  localparam int DEPTH = 8;
  localparam int FLEN  = 4;

  logic        clk = 1'b0;
  logic        rst_n, clear, simd_mode, in_valid, out_ready;
  logic [31:0] sum_in;
  logic [4:0]  shift;
  logic        out_valid, out_last, overflow, saturated;
  logic [15:0] out_data;
  logic [3:0]  fifo_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: queue of {last, data}, one pending sampled word.
  logic [16:0] mq[$];
  logic        m_st_v;
  logic [15:0] m_st_d;
  int          m_frame;
  logic        m_ovf, m_sat;
  bit          chk_en;
  int          xfer_n;
  logic [7:0]  last_mask;

  vmx_result_collector #(
    .PRODUCT_BITLEN(32),
    .FIFO_DEPTH(DEPTH),
    .FRAME_LEN(FLEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .simd_mode(simd_mode),
    .in_valid(in_valid), .sum_in(sum_in), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .fifo_count(fifo_count),
    .overflow(overflow), .saturated(saturated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // floor((v + 2^(n-1)) / 2^n) with true floor for negatives
  function automatic longint round_shift(input longint v, input int n);
    longint d, num, q;
    if (n == 0) return v;
    d   = longint'(1) << n;
    num = v + d / 2;
    q   = num / d;
    if ((num % d) != 0 && num < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint v, input longint lo, input longint hi,
                                   inout logic clip);
    if (v > hi) begin clip = 1'b1; return hi; end
    if (v < lo) begin clip = 1'b1; return lo; end
    return v;
  endfunction

  // returns {clip, data}
  function automatic logic [16:0] ref_quant(input logic simd, input logic [31:0] s,
                                            input logic [4:0] sh);
    longint a, b;
    int n;
    logic clip;
    logic [15:0] d;
    clip = 1'b0;
    if (!simd) begin
      a = clamp(round_shift(longint'($signed(s)), int'(sh)), -32768, 32767, clip);
      d = 16'(a);
    end else begin
      n = (sh > 5'd15) ? 15 : int'(sh);
      a = clamp(round_shift(longint'($signed(s[31:16])), n), -128, 127, clip);
      b = clamp(round_shift(longint'($signed(s[15:0])), n), -128, 127, clip);
      d = {8'(a), 8'(b)};
    end
    return {clip, d};
  endfunction

  // Compare settled outputs against the model, advance the model across one
  // rising edge with the currently driven inputs, then let the DUT take it.
  task automatic tick();
    logic pop;
    logic [16:0] r;
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("out_data", 32'(out_data), (mq.size() != 0) ? 32'(mq[0][15:0]) : 32'd0);
      chk("out_last", 32'(out_last), (mq.size() != 0) ? 32'(mq[0][16]) : 32'd0);
      chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("saturated", 32'(saturated), 32'(m_sat));
      if (out_valid && out_ready) begin
        if (xfer_n < 8 && out_last) last_mask[xfer_n] = 1'b1;
        xfer_n++;
      end
    end
    pop = out_ready && (mq.size() != 0);
    if (!rst_n || clear) begin
      mq.delete();
      m_st_v = 1'b0; m_frame = 0; m_ovf = 1'b0; m_sat = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_st_v) begin
        if (mq.size() < DEPTH) begin
          mq.push_back({m_frame == FLEN - 1, m_st_d});
          m_frame = (m_frame + 1) % FLEN;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_st_v = in_valid;
      if (in_valid) begin
        r = ref_quant(simd_mode, sum_in, shift);
        m_st_d = r[15:0];
        if (r[16]) m_sat = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic simd, input logic [31:0] s, input logic [4:0] sh);
    simd_mode = simd; sum_in = s; shift = sh; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; simd_mode = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; sum_in = '0; shift = '0;
    chk_en = 1'b0; xfer_n = 0; last_mask = '0;
    m_st_v = 1'b0; m_st_d = '0; m_frame = 0; m_ovf = 1'b0; m_sat = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_flags", 32'({overflow, saturated, out_last}), 32'd0);
    rst_n = 1'b1;
    tick();

    // 16-bit rounding, negative rounding, saturation
    out_ready = 1'b1;
    send(1'b0, 32'h0000_0128, 5'd4);
    tick();
    chk("rnd16", 32'(out_data), 32'h0013);
    chk("rnd16_sat", 32'(saturated), 32'd0);
    tick();
    send(1'b0, 32'hFFFF_FFD8, 5'd3);
    tick();
    chk("neg16", 32'(out_data), 32'hFFFB);
    tick();
    send(1'b0, 32'h0010_0000, 5'd0);
    tick();
    chk("sat16", 32'(out_data), 32'h7FFF);
    chk("sat16_flag", 32'(saturated), 32'd1);
    tick();
    tick();
    chk("sat_sticky", 32'(saturated), 32'd1);

    // SIMD lanes
    send(1'b1, 32'h0190_FF00, 5'd2);
    tick();
    chk("simd_rnd", 32'(out_data), 32'h64C0);
    tick();
    send(1'b1, 32'h7FFF_8000, 5'd0);
    tick();
    chk("simd_sat", 32'(out_data), 32'h7F80);
    chk("simd_sat_flag", 32'(saturated), 32'd1);
    tick();

    // Overflow with stalled consumer
    do_clear();
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) send(1'b0, 32'(i), 5'd0);
    tick();
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", 32'(out_data), 32'(i));
      tick();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Full FIFO with simultaneous pop and push
    do_clear();
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send(1'b0, 32'(256 + i), 5'd0);
    chk("full_count", 32'(fifo_count), 32'd8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("full_pop_count", 32'(fifo_count), 32'd8);
    chk("full_pop_ovf", 32'(overflow), 32'd0);
    chk("full_pop_head", 32'(out_data), 32'd258);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    chk("full_drain", 32'(out_valid), 32'd0);

    // Frame markers
    do_clear();
    xfer_n = 0; last_mask = '0;
    for (int i = 1; i <= 8; i++) send(1'b0, 32'(i * 3), 5'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("frame_last", 32'(last_mask), 32'h88);
    chk("frame_xfers", 32'(xfer_n), 32'd8);

    // Clear with words buffered, and in_valid coincident with clear
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(1'b0, 32'(i), 5'd0);
    tick();
    chk("pre_clear_count", 32'(fifo_count), 32'd3);
    clear = 1'b1; in_valid = 1'b1; sum_in = 32'h0055_0000; shift = 5'd0;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_count", 32'(fifo_count), 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_flags", 32'({overflow, saturated}), 32'd0);
    tick();
    chk("clr_drop", 32'(fifo_count), 32'd0);
    chk("clr_drop_ovf", 32'(overflow), 32'd0);
    xfer_n = 0; last_mask = '0;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(1'b0, 32'(i), 5'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("clr_frame", 32'(last_mask), 32'h08);

    // Reset mid-stream
    out_ready = 1'b0;
    send(1'b1, 32'h1234_5678, 5'd7);
    send(1'b0, 32'h8765_4321, 5'd20);
    rst_n = 1'b0; in_valid = 1'b1;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rst_mid_count", 32'(fifo_count), 32'd0);
    chk("rst_mid_data", 32'(out_data), 32'd0);
    tick();
    chk("rst_mid_drop", 32'(fifo_count), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 5);
      simd_mode = ($urandom_range(0, 15) == 0) ? ~simd_mode : simd_mode;
      case ($urandom_range(0, 2))
        0:       sum_in = $urandom;
        1:       sum_in = 32'($signed(16'($urandom)));
        default: sum_in = {8'($urandom_range(0, 1) ? 8'hFF : 8'h00), 24'($urandom)};
      endcase
      shift = 5'($urandom_range(0, 31));
      clear = ($urandom_range(0, 99) == 0);
      tick();
    end
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
